// File: rtl/board_status_leds.sv
// rtl/board_status_leds.sv - busy pulse-stretch, sticky error and heartbeat LED driver
// Optional feature macro: HEARTBEAT_EN (1 Hz blink on led[NUM_LEDS-2]).
module board_status_leds #(
    parameter real    CLK_FREQ     = 100_000_000.0,
    parameter integer NUM_CHANNELS = 2,
    parameter integer STRETCH_MS   = 50,
    parameter integer NUM_LEDS     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] busy_in,
    input  logic [NUM_CHANNELS-1:0] err_in,
    input  logic                    err_clr,
    output logic [NUM_LEDS-1:0]     led,
    output logic [7:0]              err_count
);
    localparam integer S  = $rtoi(CLK_FREQ * STRETCH_MS / 1000.0);
    localparam integer CW = (S > 0) ? $clog2(S + 1) : 1;

    if (S == 0) begin : g_bad_stretch
        $error("board_status_leds: stretch length rounds to zero cycles");
    end
    if (NUM_LEDS < NUM_CHANNELS + 2) begin : g_bad_leds
        $error("board_status_leds: NUM_LEDS must be at least NUM_CHANNELS+2");
    end

    logic [CW-1:0] cnt [NUM_CHANNELS];
    logic          err_flag;
    logic          err_q;
    logic          any_err;
    logic          err_rise;

    assign any_err  = |err_in;
    assign err_rise = any_err & ~err_q;

`ifdef HEARTBEAT_EN
    localparam integer H  = $rtoi(CLK_FREQ / 2.0);
    localparam integer HW = (H > 1) ? $clog2(H) : 1;

    logic [HW-1:0] hb_cnt;
    logic          hb_wrap;

    assign hb_wrap = (hb_cnt == HW'(H - 1));

    always_ff @(posedge clk) begin
        if (rst || hb_wrap) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + HW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            led       <= '0;
            err_flag  <= 1'b0;
            err_q     <= 1'b0;
            err_count <= 8'd0;
        end else begin
            // Busy reloads the stretch counter, so a retrigger mid-stretch leaves no gap.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt[i] <= busy_in[i] ? CW'(S) : ((cnt[i] != '0) ? cnt[i] - CW'(1) : '0);
                led[i] <= busy_in[i] | (cnt[i] != '0);
            end
            for (int j = NUM_CHANNELS; j < NUM_LEDS - 2; j++) begin
                led[j] <= 1'b0;
            end
`ifdef HEARTBEAT_EN
            led[NUM_LEDS-2] <= led[NUM_LEDS-2] ^ hb_wrap;
`else
            led[NUM_LEDS-2] <= 1'b0;
`endif
            led[NUM_LEDS-1] <= err_flag;

            err_flag <= any_err | (err_flag & ~err_clr);
            err_q    <= any_err;
            // A rising edge coincident with a clear is counted after the clear.
            if (err_clr) begin
                err_count <= {7'd0, err_rise};
            end else if (err_rise && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_board_status_leds.sv
// tb/tb_board_status_leds.sv - scoreboard bench for board_status_leds (S=10, H=5000)
`timescale 1ns/1ps
module tb_board_status_leds;
    localparam int S = 10;
    localparam int H = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  busy_in;
    logic [1:0]  err_in;
    logic        err_clr;
    logic [15:0] led;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    board_status_leds #(
        .CLK_FREQ(10_000.0), .NUM_CHANNELS(2), .STRETCH_MS(1), .NUM_LEDS(16)
    ) dut (
        .clk(clk), .rst(rst), .busy_in(busy_in), .err_in(err_in),
        .err_clr(err_clr), .led(led), .err_count(err_count)
    );

    typedef struct packed {
        logic [15:0] led;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        exp;
    int          checks = 0;
    int          failures = 0;
    int          m_cnt[2];
    int          m_count;
    int          m_hb_cnt;
    logic        m_flag, m_q, m_hb;
    logic [15:0] m_led;

    // Drive one cycle of inputs, push the model's post-edge expectation, advance past the edge.
    task automatic tick(input logic r, input logic [1:0] b, input logic [1:0] e, input logic c);
        logic any, rise;
        rst = r; busy_in = b; err_in = e; err_clr = c;
        if (r) begin
            m_cnt = '{0, 0}; m_count = 0; m_hb_cnt = 0;
            m_flag = 0; m_q = 0; m_hb = 0; m_led = '0;
        end else begin
            any  = |e;
            rise = any & ~m_q;
            for (int i = 0; i < 2; i++) begin
                m_led[i] = b[i] || (m_cnt[i] != 0);
                m_cnt[i] = b[i] ? S : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            end
            m_led[13:2] = '0;
            m_led[15]   = m_flag;
            m_flag      = any | (m_flag & ~c);
            m_q         = any;
            if (c) m_count = rise ? 1 : 0;
            else if (rise && m_count < 255) m_count++;
`ifdef HEARTBEAT_EN
            if (m_hb_cnt == H - 1) begin m_hb_cnt = 0; m_hb = ~m_hb; end
            else m_hb_cnt++;
`endif
            m_led[14] = m_hb;
        end
        sb.push_back({m_led, 8'(m_count)});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            tick(1'b1, 2'b11, 2'b11, 1'b0);
            exp = sb.pop_front(); checks++;
            if ({led, err_count} !== exp) begin failures++;
                $display("FAIL reset_sb: led=%h cnt=%0d expected led=%h cnt=%0d", led, err_count, exp.led, exp.cnt); end
            checks++;
            if (led !== 16'h0 || err_count !== 8'd0) begin failures++;
                $display("FAIL reset_hold: led=%h cnt=%0d expected led=0 cnt=0", led, err_count); end
        end
        tick(1'b0, 2'b11, 2'b11, 1'b0);
        exp = sb.pop_front(); checks++;
        if ({led, err_count} !== exp) begin failures++;
            $display("FAIL release_sb: led=%h cnt=%0d expected led=%h cnt=%0d", led, err_count, exp.led, exp.cnt); end
        checks++;
        if (led[1:0] !== 2'b11) begin failures++;
            $display("FAIL release_led: led[1:0]=%b expected 11", led[1:0]); end
        tick(1'b0, 2'b00, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 2'b00, 1'b0);
        for (int n = 0; n < 14; n++) tick(1'b0, 2'b00, 2'b00, 1'b0);
        while (sb.size() > 0) begin
            exp = sb.pop_front(); checks++;
            if (exp.cnt !== 8'd0 && n_dummy()) begin failures++;
                $display("FAIL reset_drain: cnt=%0d expected 0", exp.cnt); end
        end
        checks++;
        if (led[1:0] !== 2'b00 || led[15] !== 1'b0 || err_count !== 8'd0) begin failures++;
            $display("FAIL reset_idle: led=%h cnt=%0d expected led[1:0]=0 led[15]=0 cnt=0", led, err_count); end
    endtask

    function automatic bit n_dummy();
        return 1'b1;
    endfunction

    task automatic test_stretch();
        logic [12:0] got0;
        logic        any1 = 1'b0;
        for (int n = 0; n < 13; n++) begin
            tick(1'b0, (n == 0) ? 2'b01 : 2'b00, 2'b00, 1'b0);
            exp = sb.pop_front(); checks++;
            if ({led, err_count} !== exp) begin failures++;
                $display("FAIL stretch_sb: n=%0d led=%h expected led=%h", n, led, exp.led); end
            got0[n] = led[0];
            any1    = any1 | led[1];
        end
        checks++;
        if (got0 !== 13'h07FF) begin failures++;
            $display("FAIL stretch_shape: led0 trace=%b expected %b", got0, 13'h07FF); end
        checks++;
        if (any1 !== 1'b0) begin failures++;
            $display("FAIL stretch_other: led1 seen=%b expected 0", any1); end
    endtask

    task automatic test_retrigger();
        logic [19:0] got1;
        for (int n = 0; n < 20; n++) begin
            tick(1'b0, (n == 0 || n == 6) ? 2'b10 : 2'b00, 2'b00, 1'b0);
            exp = sb.pop_front(); checks++;
            if ({led, err_count} !== exp) begin failures++;
                $display("FAIL retrig_sb: n=%0d led=%h expected led=%h", n, led, exp.led); end
            got1[n] = led[1];
        end
        checks++;
        if (got1 !== 20'h1FFFF) begin failures++;
            $display("FAIL retrig_shape: led1 trace=%b expected %b", got1, 20'h1FFFF); end
    endtask

    task automatic test_errors();
        logic [2:0] l15;
        for (int n = 0; n < 9; n++) begin
            tick(1'b0, 2'b00, (n % 3 == 0) ? 2'b01 : 2'b00, 1'b0);
            exp = sb.pop_front(); checks++;
            if ({led, err_count} !== exp) begin failures++;
                $display("FAIL err_sb: n=%0d led=%h cnt=%0d expected led=%h cnt=%0d", n, led, err_count, exp.led, exp.cnt); end
            if (n < 3) l15[n] = led[15];
        end
        checks++;
        if (err_count !== 8'd3 || l15 !== 3'b110) begin failures++;
            $display("FAIL err_three: cnt=%0d led15 trace=%b expected cnt=3 trace=110", err_count, l15); end
        tick(1'b0, 2'b00, 2'b00, 1'b1);
        l15[0] = led[15];
        checks++;
        if (err_count !== 8'd0) begin failures++;
            $display("FAIL err_clr_cnt: cnt=%0d expected 0", err_count); end
        tick(1'b0, 2'b00, 2'b00, 1'b0);
        checks++;
        if (l15[0] !== 1'b1 || led[15] !== 1'b0) begin failures++;
            $display("FAIL err_clr_led: led15 after clr=%b then %b expected 1 then 0", l15[0], led[15]); end
        for (int n = 0; n < 5; n++) tick(1'b0, 2'b00, 2'b11, 1'b0);
        checks++;
        if (err_count !== 8'd1) begin failures++;
            $display("FAIL err_level: cnt=%0d expected 1", err_count); end
        tick(1'b0, 2'b00, 2'b00, 1'b0);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            if (sb.size() == 0) begin
                checks++;
                if ({led, err_count} !== exp) begin failures++;
                    $display("FAIL err_tail_sb: led=%h cnt=%0d expected led=%h cnt=%0d", led, err_count, exp.led, exp.cnt); end
            end
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 600; n++) begin
            tick(1'b0, 2'b00, n[0] ? 2'b00 : 2'b10, 1'b0);
            exp = sb.pop_front(); checks++;
            if ({led, err_count} !== exp) begin failures++;
                $display("FAIL sat_sb: n=%0d cnt=%0d expected %0d", n, err_count, exp.cnt); end
        end
        checks++;
        if (err_count !== 8'd255) begin failures++;
            $display("FAIL sat_255: cnt=%0d expected 255", err_count); end
        tick(1'b0, 2'b00, 2'b01, 1'b1);
        exp = sb.pop_front(); checks++;
        if (err_count !== 8'd1 || {led, err_count} !== exp) begin failures++;
            $display("FAIL clr_rise_cnt: cnt=%0d expected 1", err_count); end
        tick(1'b0, 2'b00, 2'b00, 1'b0);
        exp = sb.pop_front(); checks++;
        if (led[15] !== 1'b1 || {led, err_count} !== exp) begin failures++;
            $display("FAIL clr_rise_flag: led15=%b expected 1", led[15]); end
    endtask

    task automatic test_heartbeat();
        logic [12:0] other = '0;
        logic        hb_seen = 1'b0;
        tick(1'b1, 2'b00, 2'b00, 1'b0);
        exp = sb.pop_front();
        for (int n = 1; n <= 20000; n++) begin
            tick(1'b0, 2'b00, 2'b00, 1'b0);
            exp = sb.pop_front(); checks++;
            if ({led, err_count} !== exp) begin failures++;
                $display("FAIL hb_sb: n=%0d led=%h expected led=%h", n, led, exp.led); end
            other   = other | {1'b0, led[13:2]};
            hb_seen = hb_seen | led[14];
`ifdef HEARTBEAT_EN
            if (n == H - 1 || n == H || n == 2 * H - 1 || n == 2 * H) begin
                checks++;
                if (led[14] !== ((n == H || n == 2 * H - 1) ? 1'b1 : 1'b0)) begin failures++;
                    $display("FAIL hb_toggle: n=%0d led14=%b", n, led[14]); end
            end
`endif
        end
        checks++;
        if (other !== 13'h0) begin failures++;
            $display("FAIL unused_leds: led[13:2] seen=%h expected 0", other); end
`ifndef HEARTBEAT_EN
        checks++;
        if (hb_seen !== 1'b0) begin failures++;
            $display("FAIL hb_off: led14 seen=%b expected 0", hb_seen); end
`endif
    endtask

    initial begin
        rst = 1'b1; busy_in = '0; err_in = '0; err_clr = 1'b0;
        test_reset();
        test_stretch();
        test_retrigger();
        test_errors();
        test_saturation();
        test_heartbeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
